// File: rtl/sisc_pkg.sv
// Shared constants for the SISC control path: opcodes, FSM states, ALU modes.
package sisc_pkg;

    localparam int unsigned OPC_NOOP = 0;
    localparam int unsigned OPC_LOD  = 1;
    localparam int unsigned OPC_STR  = 2;
    localparam int unsigned OPC_SWP  = 3;
    localparam int unsigned OPC_BRA  = 4;
    localparam int unsigned OPC_BRR  = 5;
    localparam int unsigned OPC_BNE  = 6;
    localparam int unsigned OPC_BNR  = 7;
    localparam int unsigned OPC_ALU  = 8;
    localparam int unsigned OPC_HLT  = 15;

    localparam int unsigned AM_IMM_DEF = 8;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXECUTE = 4'd3,
        S_MEM     = 4'd4,
        S_WB      = 4'd5,
        S_SWP2    = 4'd6,
        S_HALT    = 4'd7,
        S_FAULT   = 4'd8
    } state_t;

    localparam logic [1:0] ALU_REG  = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

endpackage

// File: rtl/sisc_mem_timer.sv
// Wait counter for a memory handshake; flags the last permitted wait cycle.
module sisc_mem_timer #(
    parameter int MEM_TO = 15,
    parameter int TO_W   = 4
) (
    input  logic clk,
    input  logic rst_f,
    input  logic en,
    input  logic clr,
    input  logic ack,
    output logic timeout
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Counter would reach MEM_TO this cycle; a same-cycle ack takes priority.
    assign timeout = en && !ack && (cnt == TO_W'(MEM_TO - 1));

endmodule

// File: rtl/sisc_ctrl_p.sv
// Multi-cycle SISC control FSM with data-memory handshake, halt and timeout fault.
//   state   | meaning
//   RST     | PC cleared, waiting one cycle after reset release
//   FETCH   | load IR, PC <= PC+1
//   DECODE  | resolve branch, route HLT
//   EXECUTE | ALU op or address pass-through
//   MEM     | data memory request/ack wait (LOD/STR)
//   WB      | register write-back
//   SWP2    | second write of SWP
//   HALT    | HLT executed, idle until reset
//   FAULT   | memory timeout, idle until reset
module sisc_ctrl_p
    import sisc_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int ST_W   = 4,
    parameter int AM_IMM = AM_IMM_DEF,
    parameter int MEM_TO = 15,
    parameter int TO_W   = 4
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [OP_W-1:0] opcode,
    input  logic [ST_W-1:0] mm,
    input  logic [ST_W-1:0] stat,
    input  logic            mem_ack,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            br_sel,
    output logic            pc_sel,
    output logic            pc_write,
    output logic            pc_rst,
    output logic            ir_load,
    output logic            rb_sel,
    output logic [1:0]      alu_op,
    output logic            mem_req,
    output logic            dm_we,
    output logic            swp_ph,
    output logic            halted,
    output logic            fault
);

    state_t state, state_nxt;
    logic   timeout;

    logic is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt;
    logic any_hit, br_taken;
    logic [1:0] alu_mode;

    assign is_lod = (opcode == OP_W'(OPC_LOD));
    assign is_str = (opcode == OP_W'(OPC_STR));
    assign is_swp = (opcode == OP_W'(OPC_SWP));
    assign is_bra = (opcode == OP_W'(OPC_BRA));
    assign is_brr = (opcode == OP_W'(OPC_BRR));
    assign is_bne = (opcode == OP_W'(OPC_BNE));
    assign is_bnr = (opcode == OP_W'(OPC_BNR));
    assign is_alu = (opcode == OP_W'(OPC_ALU));
    assign is_hlt = (opcode == OP_W'(OPC_HLT));

    assign any_hit  = ((stat & mm) != '0);
    assign br_taken = ((is_bra || is_brr) && any_hit) || ((is_bne || is_bnr) && !any_hit);
    assign alu_mode = (mm == ST_W'(AM_IMM)) ? ALU_IMM : ALU_REG;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        br_sel    = 1'b0;
        pc_sel    = 1'b0;
        pc_write  = 1'b0;
        pc_rst    = 1'b0;
        ir_load   = 1'b0;
        rb_sel    = 1'b0;
        alu_op    = ALU_PASS;
        mem_req   = 1'b0;
        dm_we     = 1'b0;
        swp_ph    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            S_RST: begin
                pc_rst    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                pc_write  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                br_sel = is_bra || is_bne;
                if (br_taken) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                end
                state_nxt = is_hlt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_alu) alu_op = alu_mode;
                state_nxt = S_MEM;
            end
            S_MEM: begin
                if (is_alu) alu_op = alu_mode;
                state_nxt = S_WB;
                if (is_lod || is_str) begin
                    mem_req = 1'b1;
                    dm_we   = is_str;
                    if (!mem_ack) state_nxt = timeout ? S_FAULT : S_MEM;
                end
            end
            S_WB: begin
                rb_sel    = 1'b1;
                rf_we     = is_alu || is_lod || is_swp;
                wb_sel    = is_lod;
                state_nxt = is_swp ? S_SWP2 : S_FETCH;
            end
            S_SWP2: begin
                rf_we     = 1'b1;
                rb_sel    = 1'b1;
                swp_ph    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nxt = S_RST;
        endcase
    end

    sisc_mem_timer #(
        .MEM_TO (MEM_TO),
        .TO_W   (TO_W)
    ) u_mem_timer (
        .clk     (clk),
        .rst_f   (rst_f),
        .en      ((state == S_MEM) && (is_lod || is_str)),
        .clr     (state_nxt != S_MEM),
        .ack     (mem_ack),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_sisc_ctrl_p.sv
// Randomized bench for sisc_ctrl_p: per-instruction expected output traces built from the instruction rules.
module tb_sisc_ctrl_p;

    localparam logic [14:0] F_FAULT = 15'h0001;
    localparam logic [14:0] F_HALT  = 15'h0002;
    localparam logic [14:0] F_SWP   = 15'h0004;
    localparam logic [14:0] F_DMWE  = 15'h0008;
    localparam logic [14:0] F_MREQ  = 15'h0010;
    localparam logic [14:0] A_REG   = 15'h0000;
    localparam logic [14:0] A_IMM   = 15'h0020;
    localparam logic [14:0] A_PASS  = 15'h0040;
    localparam logic [14:0] F_RBS   = 15'h0080;
    localparam logic [14:0] F_IRL   = 15'h0100;
    localparam logic [14:0] F_PCRST = 15'h0200;
    localparam logic [14:0] F_PCW   = 15'h0400;
    localparam logic [14:0] F_PCS   = 15'h0800;
    localparam logic [14:0] F_BRS   = 15'h1000;
    localparam logic [14:0] F_WBS   = 15'h2000;
    localparam logic [14:0] F_RFWE  = 15'h4000;
    localparam int MEM_TO = 15;

    logic       clk = 1'b0;
    logic       rst_f = 1'b0;
    logic [3:0] opcode = '0;
    logic [3:0] mm = '0;
    logic [3:0] stat = '0;
    logic       mem_ack = 1'b0;
    logic rf_we, wb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load, rb_sel;
    logic [1:0] alu_op;
    logic mem_req, dm_we, swp_ph, halted, fault;
    logic [14:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sisc_ctrl_p #(
        .OP_W(4), .ST_W(4), .AM_IMM(8), .MEM_TO(MEM_TO), .TO_W(4)
    ) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_ack(mem_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .br_sel(br_sel), .pc_sel(pc_sel), .pc_write(pc_write),
        .pc_rst(pc_rst), .ir_load(ir_load), .rb_sel(rb_sel), .alu_op(alu_op), .mem_req(mem_req),
        .dm_we(dm_we), .swp_ph(swp_ph), .halted(halted), .fault(fault)
    );

    assign obs = {rf_we, wb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load, rb_sel,
                  alu_op, mem_req, dm_we, swp_ph, halted, fault};

    // Called at a negedge; leaves the DUT one edge away from its first FETCH.
    task automatic do_reset(input string tag);
        #1;
        rst_f   = 1'b0;
        mem_ack = 1'b0;
        #1;
        checks++;
        if (obs !== (F_PCRST | A_PASS)) begin
            errors++;
            $display("FAIL %s_async: got %b expected %b", tag, obs, F_PCRST | A_PASS);
        end
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== (F_PCRST | A_PASS)) begin
            errors++;
            $display("FAIL %s_release: got %b expected %b", tag, obs, F_PCRST | A_PASS);
        end
    endtask

    // Builds the expected per-cycle trace of one instruction, then drives and checks it.
    // ack_at: MEM cycle index carrying the ack (<0 or >=MEM_TO: never); stop_mem: abort after that
    // many MEM cycles (<0: run to completion); tail: cycles observed after HALT/FAULT entry.
    task automatic run_instr(input string tag, input int op, input logic [3:0] m, input logic [3:0] s,
                             input int ack_at, input int stop_mem, input int tail);
        logic [14:0] expq[$];
        bit          ackq[$];
        bit          br, taken, memop, done, aborted, faulted;
        logic [14:0] aluv, dec;
        br      = (op == 4) || (op == 6);
        taken   = ((op == 4 || op == 5) && ((s & m) != 4'd0)) ||
                  ((op == 6 || op == 7) && ((s & m) == 4'd0));
        memop   = (op == 1) || (op == 2);
        aluv    = (op == 8) ? ((m == 4'd8) ? A_IMM : A_REG) : A_PASS;
        dec     = A_PASS | (br ? F_BRS : 15'h0) | (taken ? (F_PCS | F_PCW) : 15'h0);
        aborted = 1'b0;
        faulted = 1'b0;

        expq.push_back(F_IRL | F_PCW | A_PASS);
        ackq.push_back(1'($urandom));
        expq.push_back(dec);
        ackq.push_back(1'($urandom));
        if (op == 15) begin
            repeat (tail) begin
                expq.push_back(A_PASS | F_HALT);
                ackq.push_back(1'($urandom));
            end
        end else begin
            expq.push_back(aluv);
            ackq.push_back(1'($urandom));
            if (memop) begin
                done = 1'b0;
                for (int k = 0; k < MEM_TO && !done; k++) begin
                    if (stop_mem >= 0 && k == stop_mem) begin
                        done    = 1'b1;
                        aborted = 1'b1;
                    end else begin
                        expq.push_back(A_PASS | F_MREQ | ((op == 2) ? F_DMWE : 15'h0));
                        ackq.push_back(k == ack_at);
                        if (k == ack_at) done = 1'b1;
                    end
                end
                faulted = !aborted && !(ack_at >= 0 && ack_at < MEM_TO);
            end else begin
                expq.push_back(aluv);
                ackq.push_back(1'($urandom));
            end
            if (faulted) begin
                repeat (tail) begin
                    expq.push_back(A_PASS | F_FAULT);
                    ackq.push_back(1'($urandom));
                end
            end else if (!aborted) begin
                expq.push_back(A_PASS | F_RBS | ((op == 8 || op == 1 || op == 3) ? F_RFWE : 15'h0) |
                               ((op == 1) ? F_WBS : 15'h0));
                ackq.push_back(1'($urandom));
                if (op == 3) begin
                    expq.push_back(A_PASS | F_RBS | F_RFWE | F_SWP);
                    ackq.push_back(1'($urandom));
                end
            end
        end

        for (int i = 0; i < expq.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                opcode = 4'(op);
                mm     = m;
                stat   = s;
            end
            mem_ack = ackq[i];
            @(negedge clk);
            checks++;
            if (obs !== expq[i]) begin
                errors++;
                $display("FAIL %s op=%0d cycle %0d: got %b expected %b", tag, op, i, obs, expq[i]);
            end
        end
        mem_ack = 1'b0;
    endtask

    function automatic int rand_noop_op();
        int v;
        v = $urandom_range(0, 6);
        return (v == 0) ? 0 : v + 8;
    endfunction

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_noop_stream();
        for (int i = 0; i < 5; i++)
            run_instr("noop", rand_noop_op(), 4'($urandom), 4'($urandom), -1, -1, 0);
    endtask

    task automatic test_alu();
        run_instr("alu_imm", 8, 4'd8, 4'($urandom), -1, -1, 0);
        run_instr("alu_reg", 8, 4'd0, 4'($urandom), -1, -1, 0);
        for (int i = 0; i < 4; i++)
            run_instr("alu_rand", 8, 4'($urandom), 4'($urandom), -1, -1, 0);
    endtask

    task automatic test_branch();
        run_instr("bra_taken", 4, 4'b0010, 4'b0010, -1, -1, 0);
        run_instr("bnr_taken", 7, 4'b0001, 4'b0010, -1, -1, 0);
        run_instr("brr_not",   5, 4'b0001, 4'b0100, -1, -1, 0);
        for (int i = 0; i < 10; i++)
            run_instr("br_rand", $urandom_range(4, 7), 4'($urandom), 4'($urandom), -1, -1, 0);
    endtask

    task automatic test_mem();
        run_instr("lod_ack3", 1, 4'($urandom), 4'($urandom), 3, -1, 0);
        run_instr("str_rand", 2, 4'($urandom), 4'($urandom), $urandom_range(0, 5), -1, 0);
        run_instr("lod_ack0", 1, 4'($urandom), 4'($urandom), 0, -1, 0);
        run_instr("lod_ack_last", 1, 4'($urandom), 4'($urandom), MEM_TO - 1, -1, 0);
        run_instr("str_ack_last", 2, 4'($urandom), 4'($urandom), MEM_TO - 1, -1, 0);
    endtask

    task automatic test_fault();
        run_instr("lod_timeout", 1, 4'($urandom), 4'($urandom), -1, -1, 4);
        do_reset("fault_clear");
        run_instr("after_fault", 8, 4'd8, 4'($urandom), -1, -1, 0);
        run_instr("str_late_ack", 2, 4'($urandom), 4'($urandom), MEM_TO, -1, 3);
        do_reset("fault_clear2");
    endtask

    task automatic test_swp();
        run_instr("swp", 3, 4'($urandom), 4'($urandom), -1, -1, 0);
        run_instr("after_swp", 0, 4'($urandom), 4'($urandom), -1, -1, 0);
    endtask

    task automatic test_back_to_back();
        int ops[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11};
        for (int i = 0; i < 20; i++)
            run_instr("b2b", ops[$urandom_range(0, 9)], 4'($urandom), 4'($urandom),
                      $urandom_range(0, 6), -1, 0);
    endtask

    task automatic test_halt();
        run_instr("hlt", 15, 4'($urandom), 4'($urandom), -1, -1, 5);
        do_reset("halt_clear");
    endtask

    task automatic test_reset_mid_lod();
        run_instr("lod_abort", 1, 4'($urandom), 4'($urandom), -1, 2, 0);
        do_reset("mid_lod");
        run_instr("after_abort", 8, 4'd0, 4'($urandom), -1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_noop_stream();
        test_alu();
        test_branch();
        test_mem();
        test_fault();
        test_swp();
        test_back_to_back();
        test_halt();
        test_reset_mid_lod();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sisc_ctrl_p.md
Name: sisc_ctrl_p

Overview:
Parametrised multi-cycle control FSM for the SISC datapath. It is the successor to the fixed 4-bit controller and adds:
- full LOD/STR/SWP sequencing;
- a data-memory request/acknowledge handshake with a timeout fault;
- a real halt state in place of a simulation stop;
- parametrised opcode and status widths.
It sits between the IR/status register and the datapath control points: PC, register file, ALU, write-back mux and data memory.

Parameters:
OP_W, 4, opcode field width.
ST_W, 4, width of stat and mm (condition mask).
AM_IMM, 8, mm value selecting ALU immediate mode.
MEM_TO, 15, max MEM-state wait cycles before fault (>=1).
TO_W, 4, timeout counter width; must satisfy 2^TO_W > MEM_TO.

Ports:
clk  in  1  clock, rising edge.
rst_f  in  1  asynchronous active-low reset.
opcode  in  OP_W  IR opcode field.
mm  in  ST_W  IR mode/mask field.
stat  in  ST_W  status register.
mem_ack  in  1  data memory done (one-cycle pulse or level).
rf_we  out  1  register file write enable.
wb_sel  out  1  write-back source: 0=ALU, 1=memory.
br_sel  out  1  branch target: 1=absolute (BRA/BNE), 0=relative.
pc_sel  out  1  PC source: 0=PC+1, 1=branch target.
pc_write  out  1  PC load.
pc_rst  out  1  PC clear.
ir_load  out  1  IR load.
rb_sel  out  1  register-file read port B select.
alu_op  out  2  00=reg op, 01=immediate op, 10=pass/address.
mem_req  out  1  data memory request.
dm_we  out  1  data memory write (valid with mem_req).
swp_ph  out  1  SWP second-write phase (selects second destination).
halted  out  1  HLT reached.
fault  out  1  memory timeout (sticky).

Behaviour:
- Reset (rst_f=0, asynchronous): state=RST, timeout counter=0. While in RST: pc_rst=1 and every other output at its default. Defaults are 0, except alu_op=10.
- Outputs are combinational from state, opcode, mm and stat. Any output not driven in a state takes its default (no latches).
- Opcodes: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15. All others are treated as NOOP.
- Branch taken:
  - BRA/BRR taken when (stat & mm) != 0.
  - BNE/BNR taken when (stat & mm) == 0.
- State sequence:
  - RST -> FETCH (always, one cycle after rst_f deasserts).
  - FETCH: ir_load=1, pc_write=1, pc_sel=0 -> DECODE.
  - DECODE:
    - br_sel=1 for BRA/BNE, 0 otherwise.
    - If branch taken: pc_sel=1, pc_write=1.
    - HLT -> HALT; otherwise -> EXECUTE.
  - EXECUTE:
    - ALU: alu_op=01 if mm==AM_IMM, else 00.
    - LOD/STR/SWP: alu_op=10 (address).
    - -> MEM.
  - MEM:
    - ALU: alu_op held as in EXECUTE, -> WB.
    - LOD/STR: mem_req=1; dm_we=1 for STR.
      - Stays in MEM until mem_ack=1, then -> WB.
      - Counter increments each waiting cycle. When the counter reaches MEM_TO with no ack -> FAULT.
      - An ack in the same cycle the counter hits MEM_TO wins (-> WB).
    - Other opcodes: no request, -> WB.
    - Counter clears on MEM exit.
  - WB:
    - rb_sel=1.
    - rf_we=1 for ALU, LOD, SWP; wb_sel=1 for LOD.
    - SWP -> SWP2; otherwise -> FETCH.
  - SWP2: rf_we=1, rb_sel=1, swp_ph=1 -> FETCH.
  - HALT: halted=1, all enables 0. Stays until reset.
  - FAULT: fault=1, all enables 0. Stays until reset.
- Unused state encodings -> RST.
- Reset mid-MEM: mem_req drops immediately (asynchronous), the counter clears, and no write-back occurs.
- Instruction latency in cycles: ALU/NOOP/branch = 5; LOD/STR = 5 + wait cycles; SWP = 6; HLT = 2 to HALT.

Decomposition:
- Shared package sisc_pkg holds:
  - opcode constants;
  - state enumeration constants;
  - alu_op encodings;
  - AM_IMM default.
- One natural sub-module: sisc_mem_timer. It is the MEM-state wait counter: inputs enable/clear/ack, output timeout. It is reused later by the fetch-side handshake.

Test Plan:
- Reset, then NOOP stream -> pc_rst=1 only in RST; ir_load/pc_write pulse every 5th cycle starting at the first FETCH; rf_we never 1.
- ALU with mm=8, then mm=0 -> alu_op=01 in EXECUTE/MEM for the first, 00 for the second; rf_we=1 in WB only.
- BRA with stat=0010, mm=0010 -> DECODE has br_sel=1, pc_sel=1, pc_write=1. BNR with stat=0010, mm=0001 -> br_sel=0, pc_sel=1. BRR with stat=0100, mm=0001 -> pc_write=0 in DECODE.
- LOD with mem_ack after 3 cycles -> mem_req high for 4 cycles, then WB has rf_we=1, wb_sel=1. STR -> dm_we=1 with mem_req, rf_we=0. With MEM_TO=15 and ack withheld -> fault=1 after 15 MEM cycles, sticky; rst_f low clears it.
- SWP -> WB rf_we=1, swp_ph=0; SWP2 rf_we=1, swp_ph=1; next cycle FETCH.
- HLT -> halted=1 from the cycle after DECODE, no further ir_load. Asserting rst_f low mid-LOD -> mem_req=0 in the same cycle, FETCH one cycle after release.
